// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Next-PC select encoding is also consumed by the hazard unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PCSEL_SEQ    = 2'd0,
        PCSEL_HOLD   = 2'd1,
        PCSEL_BRANCH = 2'd2,
        PCSEL_RAS    = 2'd3
    } pc_sel_e;

    localparam int RAS_DEPTH_MIN = 2;

    function automatic logic is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
// Flags are sticky until reset.
module fetch_ras
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              do_pop;

    assign top_ptr = wr_ptr - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (pop && empty) underflow <= 1'b1;
            // Simultaneous pop+push: old top already consumed, new value replaces it.
            if (push && do_pop) begin
                mem[top_ptr] <= push_addr;
            end else if (push) begin
                mem[wr_ptr] <= push_addr;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                if (full) overflow <= 1'b1;
                else      count    <= count + CNT_W'(1);
            end else if (do_pop) begin
                wr_ptr <= top_ptr;
                count  <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC select and IF/ID register.
// Optional return-address stack enabled by defining FETCH_RAS_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W       = 16,
    parameter int                 INSTR_W      = 16,
    parameter int                 PC_STEP      = 2,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_next,
    output logic [INSTR_W-1:0] ifid_instr
`ifdef FETCH_RAS_EN
    ,
    input  logic               ras_push,
    input  logic [ADDR_W-1:0]  ras_push_addr,
    input  logic               ras_pop,
    output logic               ras_overflow,
    output logic               ras_underflow
`endif
);

    if ((RAS_DEPTH < RAS_DEPTH_MIN) || !is_pow2(RAS_DEPTH)) begin : g_bad_ras_depth
        $error("fetch_unit: RAS_DEPTH must be a power of 2 and >= 2");
    end

    logic              rst_sync_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_take;
    logic              redirect;
    pc_sel_e           pc_sel;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_n <= 1'b0;
        else          rst_sync_n <= 1'b1;
    end

`ifdef FETCH_RAS_EN
    logic ras_empty;

    fetch_ras #(
        .DEPTH  (RAS_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset_n   (rst_sync_n),
        .push      (ras_push),
        .push_addr (ras_push_addr),
        .pop       (ras_pop),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    assign ras_take = ras_pop && !ras_empty;
`else
    assign ras_take = 1'b0;
    assign ras_top  = '0;
`endif

    assign pc_inc    = pc + ADDR_W'(PC_STEP);
    assign imem_addr = pc;
    assign redirect  = branch_taken || ras_take;

    always_comb begin
        pc_sel = PCSEL_SEQ;
        if (branch_taken)  pc_sel = PCSEL_BRANCH;
        else if (ras_take) pc_sel = PCSEL_RAS;
        else if (stall)    pc_sel = PCSEL_HOLD;
    end

    always_comb begin
        case (pc_sel)
            PCSEL_BRANCH: pc_next = branch_target;
            PCSEL_RAS:    pc_next = ras_top;
            PCSEL_HOLD:   pc_next = pc;
            default:      pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pc           <= RESET_VECTOR;
            ifid_valid   <= 1'b0;
            ifid_pc      <= '0;
            ifid_pc_next <= '0;
            ifid_instr   <= '0;
        end else begin
            pc <= pc_next;
            if (redirect || flush) begin
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                ifid_valid   <= 1'b1;
                ifid_pc      <= pc;
                ifid_pc_next <= pc_inc;
                ifid_instr   <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (default build and FETCH_RAS_EN build).
module tb_fetch_unit;

    localparam logic [15:0] XORK = 16'h5A5A;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] imem_addr, imem_rdata, ifid_pc, ifid_pc_next, ifid_instr;
    logic        ifid_valid;
    logic [15:0] w_imem_addr, w_imem_rdata, w_ifid_pc, w_ifid_pc_next, w_ifid_instr;
    logic        w_ifid_valid;
`ifdef FETCH_RAS_EN
    logic        ras_push = 1'b0, ras_pop = 1'b0;
    logic [15:0] ras_push_addr = '0;
    logic        ras_overflow, ras_underflow, w_ras_overflow, w_ras_underflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc, m_ipc, m_ipn, m_instr;
    logic        m_valid, m_sync, m_of, m_uf;
    logic [15:0] m_ras[$];

    assign imem_rdata   = imem_addr ^ XORK;
    assign w_imem_rdata = w_imem_addr ^ XORK;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_next  (ifid_pc_next),
        .ifid_instr    (ifid_instr)
`ifdef FETCH_RAS_EN
        ,
        .ras_push      (ras_push),
        .ras_push_addr (ras_push_addr),
        .ras_pop       (ras_pop),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
`endif
    );

    fetch_unit #(.RESET_VECTOR(16'hFFFC)) dut_w (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (1'b0),
        .flush         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (16'h0000),
        .imem_addr     (w_imem_addr),
        .imem_rdata    (w_imem_rdata),
        .ifid_valid    (w_ifid_valid),
        .ifid_pc       (w_ifid_pc),
        .ifid_pc_next  (w_ifid_pc_next),
        .ifid_instr    (w_ifid_instr)
`ifdef FETCH_RAS_EN
        ,
        .ras_push      (1'b0),
        .ras_push_addr (16'h0000),
        .ras_pop       (1'b0),
        .ras_overflow  (w_ras_overflow),
        .ras_underflow (w_ras_underflow)
`endif
    );

    function automatic logic [64:0] obs_vec();
        return {imem_addr, ifid_valid, ifid_pc, ifid_pc_next, ifid_instr};
    endfunction

    function automatic logic [64:0] exp_vec();
        return {m_pc, m_valid, m_ipc, m_ipn, m_instr};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_valid = 0; m_ipc = '0; m_ipn = '0; m_instr = '0;
        m_sync = 0; m_of = 0; m_uf = 0;
        m_ras.delete();
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; branch_taken = 0; branch_target = '0;
`ifdef FETCH_RAS_EN
        ras_push = 0; ras_pop = 0; ras_push_addr = '0;
`endif
    endtask

    // Advance the model by one edge from the current inputs, then clock the DUT.
    task automatic step();
        logic        hit;
        logic [15:0] rtop;
        hit = 0;
        rtop = '0;
        if (!m_sync) begin
            m_sync = 1;
        end else begin
`ifdef FETCH_RAS_EN
            hit = ras_pop && (m_ras.size() > 0);
            if (hit) rtop = m_ras[$];
`endif
            if (branch_taken || hit || flush) begin
                m_valid = 0;
            end else if (!stall) begin
                m_valid = 1; m_ipc = m_pc; m_ipn = m_pc + 16'd2; m_instr = m_pc ^ XORK;
            end
            if (branch_taken) m_pc = branch_target;
            else if (hit)     m_pc = rtop;
            else if (!stall)  m_pc = m_pc + 16'd2;
`ifdef FETCH_RAS_EN
            if (ras_pop) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_uf = 1;
            end
            if (ras_push) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_of = 1;
                end
                m_ras.push_back(ras_push_addr);
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== 65'd0) begin
            errors++; $display("FAIL reset_state got %h want %h", obs_vec(), 65'd0);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_first_edge valid=%b addr=%h want 0/0000", ifid_valid, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 16'(2 * i) || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL sequential[%0d] got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stall();
        logic [64:0] frozen;
        checks++;
        if (imem_addr !== 16'h0008) begin
            errors++; $display("FAIL stall_start addr=%h want 0008", imem_addr);
        end
        frozen = obs_vec();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_vec() !== frozen || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stall_hold[%0d] got %h want %h", i, obs_vec(), frozen);
            end
        end
        stall = 0;
        step();
        checks++;
        if (imem_addr !== 16'h000A || ifid_pc !== 16'h0008 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL stall_release got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_branch_stall();
        stall = 1; branch_taken = 1; branch_target = 16'h0100;
        step();
        checks++;
        if (imem_addr !== 16'h0100 || ifid_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL branch_stall got %h want %h", obs_vec(), exp_vec());
        end
        clear_inputs();
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0100 || ifid_instr !== (16'h0100 ^ XORK)) begin
            errors++; $display("FAIL branch_target_fetch got %h want pc 0100", obs_vec());
        end
    endtask

    task automatic test_flush();
        branch_taken = 1; branch_target = 16'd20;
        step();
        clear_inputs();
        flush = 1;
        step();
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 16'd22 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL flush_only got %h want %h", obs_vec(), exp_vec());
        end
        flush = 0;
        step();
        checks++;
        if (ifid_pc !== 16'd22 || ifid_valid !== 1'b1) begin
            errors++; $display("FAIL flush_resume pc=%h valid=%b want 0016/1", ifid_pc, ifid_valid);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ea;
        do_reset();
        step();
        checks++;
        if (w_imem_addr !== 16'hFFFC || w_ifid_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_reset addr=%h valid=%b want fffc/0", w_imem_addr, w_ifid_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            ea = 16'hFFFC + 16'(2 * k);
            checks++;
            if ({w_imem_addr, w_ifid_valid, w_ifid_pc, w_ifid_pc_next, w_ifid_instr} !==
                {ea, 1'b1, ea - 16'd2, ea, (ea - 16'd2) ^ XORK} ||
                $isunknown({w_imem_addr, w_ifid_pc, w_ifid_pc_next, w_ifid_instr})) begin
                errors++; $display("FAIL wrap[%0d] addr=%h pc=%h next=%h want addr %h", k,
                                   w_imem_addr, w_ifid_pc, w_ifid_pc_next, ea);
            end
        end
`ifdef FETCH_RAS_EN
        checks++;
        if (w_ras_overflow !== 1'b0 || w_ras_underflow !== 1'b0) begin
            errors++; $display("FAIL wrap_ras_flags got %b%b want 00", w_ras_overflow, w_ras_underflow);
        end
`endif
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin
                #2 reset_n = 0;
                model_reset();
                #1;
                checks++;
                if (obs_vec() !== 65'd0) begin
                    errors++; $display("FAIL reset_mid_run got %h want 0", obs_vec());
                end
                @(posedge clk); #1;
                reset_n = 1;
            end
            stall         = ($urandom_range(3) == 0);
            flush         = ($urandom_range(7) == 0);
            branch_taken  = ($urandom_range(7) == 0);
            branch_target = 16'($urandom) & 16'hFFFE;
`ifdef FETCH_RAS_EN
            ras_push      = ($urandom_range(3) == 0);
            ras_pop       = ($urandom_range(3) == 0);
            ras_push_addr = 16'($urandom) & 16'hFFFE;
`endif
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (bad < 5) $display("FAIL random[%0d] got %h want %h", n, obs_vec(), exp_vec());
                bad++;
            end
`ifdef FETCH_RAS_EN
            checks++;
            if ({ras_overflow, ras_underflow} !== {m_of, m_uf}) begin
                errors++;
                if (bad < 5) $display("FAIL random_flags[%0d] got %b%b want %b%b", n,
                                      ras_overflow, ras_underflow, m_of, m_uf);
                bad++;
            end
`endif
        end
        clear_inputs();
    endtask

`ifdef FETCH_RAS_EN
    task automatic test_ras();
        logic [15:0] want;
        do_reset();
        step();
        ras_push = 1; ras_push_addr = 16'h0040; step();
        ras_push_addr = 16'h0050; step();
        ras_push = 0; ras_pop = 1;
        step();
        checks++;
        if (imem_addr !== 16'h0050 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL ras_pop1 addr=%h want 0050", imem_addr);
        end
        step();
        checks++;
        if (imem_addr !== 16'h0040) begin
            errors++; $display("FAIL ras_pop2 addr=%h want 0040", imem_addr);
        end
        step();
        checks++;
        if (imem_addr !== 16'h0042 || ras_underflow !== 1'b1 || ras_overflow !== 1'b0) begin
            errors++; $display("FAIL ras_underflow addr=%h uf=%b want 0042/1", imem_addr, ras_underflow);
        end
        ras_pop = 0; ras_push = 1;
        for (int i = 0; i < 5; i++) begin
            ras_push_addr = 16'h0200 + 16'(16 * i);
            step();
        end
        checks++;
        if (ras_overflow !== 1'b1) begin
            errors++; $display("FAIL ras_overflow got %b want 1", ras_overflow);
        end
        ras_push = 0; ras_pop = 1;
        for (int i = 4; i >= 1; i--) begin
            step();
            want = 16'h0200 + 16'(16 * i);
            checks++;
            if (imem_addr !== want || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL ras_overflow_pop[%0d] addr=%h want %h", i, imem_addr, want);
            end
        end
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_stall();
        test_branch_stall();
        test_flush();
        test_wrap();
        test_random();
`ifdef FETCH_RAS_EN
        test_ras();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
